// File: rtl/dbg_pkg.sv
// Shared definitions for the register-file debug dump path.
package dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_ADDR,
    ST_WAIT,
    ST_SEND,
    ST_CSUM,
    ST_DONE
  } dump_state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Sync byte + all register bytes + checksum byte.
  function automatic int unsigned frame_len(input int unsigned num_regs,
                                            input int unsigned data_w);
    return 2 + num_regs * (data_w / 8);
  endfunction

endpackage

// File: rtl/dbg_byte_serializer.sv
// Holds one captured register word and hands out its bytes MSB first.
module dbg_byte_serializer #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic              shift_i,
  output logic [7:0]        next_byte_o,
  output logic              last_o
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned CNT_W = (NB > 1) ? $clog2(NB) : 1;

  logic [DATA_W-1:0] rest_q;
  logic [CNT_W-1:0]  idx_q;

  // The top byte goes straight to the output register on load, so only the
  // remaining bytes are kept here; idx_q tracks the byte currently on the bus.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rest_q <= '0;
      idx_q  <= '0;
    end else if (load_i) begin
      rest_q <= word_i << 8;
      idx_q  <= '0;
    end else if (shift_i) begin
      rest_q <= rest_q << 8;
      idx_q  <= idx_q + CNT_W'(1);
    end
  end

  assign next_byte_o = rest_q[DATA_W-1 -: 8];
  assign last_o      = (idx_q == CNT_W'(NB - 1));

endmodule

// File: rtl/reg_dump_reader.sv
// Walks the register file debug port and streams a framed byte dump:
// sync byte, each register MSB first, XOR checksum of the register bytes.
module reg_dump_reader
  import dbg_pkg::*;
#(
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] read_address_debug,
  input  logic [DATA_W-1:0] data_out_debug,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned WAIT_W = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  dump_state_e       state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WAIT_W-1:0] wait_q;
  logic [7:0]        csum_q;
  logic [7:0]        csum_d;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;
  logic              busy_q;
  logic              done_q;

  logic              tx_hs;
  logic              ser_load;
  logic              ser_shift;
  logic [7:0]        ser_byte;
  logic              ser_last;

  assign tx_hs     = tx_valid_q & tx_ready;
  assign csum_d    = csum_q ^ tx_data_q;
  assign ser_load  = (state_q == ST_WAIT) && (wait_q == '0);
  assign ser_shift = (state_q == ST_SEND) && tx_hs && !ser_last;

  dbg_byte_serializer #(
    .DATA_W (DATA_W)
  ) u_ser (
    .clk_i       (clock),
    .rst_i       (reset),
    .load_i      (ser_load),
    .word_i      (data_out_debug),
    .shift_i     (ser_shift),
    .next_byte_o (ser_byte),
    .last_o      (ser_last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wait_q     <= '0;
      csum_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (abort && (state_q != ST_IDLE)) begin
      state_q    <= ST_IDLE;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            state_q    <= ST_SYNC;
            busy_q     <= 1'b1;
            addr_q     <= '0;
            csum_q     <= '0;
            tx_data_q  <= SYNC_BYTE;
            tx_valid_q <= 1'b1;
          end
        end
        ST_SYNC: begin
          if (tx_hs) begin
            tx_valid_q <= 1'b0;
            state_q    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          wait_q  <= WAIT_W'(READ_LATENCY);
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_q == '0) begin
            tx_data_q  <= data_out_debug[DATA_W-1 -: 8];
            tx_valid_q <= 1'b1;
            state_q    <= ST_SEND;
          end else begin
            wait_q <= wait_q - WAIT_W'(1);
          end
        end
        ST_SEND: begin
          // The last data byte flows straight into the checksum byte without a bubble.
          if (tx_hs) begin
            csum_q <= csum_d;
            if (!ser_last) begin
              tx_data_q <= ser_byte;
            end else if (addr_q == LAST_ADDR) begin
              tx_data_q <= csum_d;
              state_q   <= ST_CSUM;
            end else begin
              tx_valid_q <= 1'b0;
              addr_q     <= addr_q + ADDR_W'(1);
              state_q    <= ST_ADDR;
            end
          end
        end
        ST_CSUM: begin
          if (tx_hs) begin
            tx_valid_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign read_address_debug = addr_q;
  assign tx_data            = tx_data_q;
  assign tx_valid           = tx_valid_q;
  assign busy               = busy_q;
  assign done               = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: two instances (read latency 1 and 3) against a
// frame model built directly from the register contents.
module tb_reg_dump_reader;
  import dbg_pkg::*;

  localparam int unsigned NREG = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_s[2];
  logic        abort_s[2];
  logic        tx_ready_s[2];
  logic        tx_valid_s[2];
  logic        busy_s[2];
  logic        done_s[2];
  logic [4:0]  addr_s[2];
  logic [31:0] dout_s[2];
  logic [7:0]  tx_data_s[2];

  logic [31:0] mem[2][NREG];
  logic [4:0]  ap0;
  logic [4:0]  ap1[3];
  int unsigned rdy_pct[2] = '{100, 100};
  logic [7:0]  got_q[2][$];
  logic [7:0]  exp_q[$];
  int          done_cnt[2];
  bit          prev_stall[2];
  logic [7:0]  stall_byte[2];
  bit          mut_en;
  int          n_assert = 0;
  int          n_fail = 0;

  typedef struct {
    bit         start;
    bit         exp_valid;
    logic [7:0] exp_data;
    bit         exp_busy;
    logic [4:0] exp_addr;
  } vec_t;
  vec_t tbl[12];

  always #5 clk = ~clk;

  reg_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .READ_LATENCY(1), .SYNC_BYTE(8'hA5)) u_dut0 (
    .clock(clk), .reset(rst), .start(start_s[0]), .abort(abort_s[0]),
    .read_address_debug(addr_s[0]), .data_out_debug(dout_s[0]),
    .tx_data(tx_data_s[0]), .tx_valid(tx_valid_s[0]), .tx_ready(tx_ready_s[0]),
    .busy(busy_s[0]), .done(done_s[0]));

  reg_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .READ_LATENCY(3), .SYNC_BYTE(8'hA5)) u_dut1 (
    .clock(clk), .reset(rst), .start(start_s[1]), .abort(abort_s[1]),
    .read_address_debug(addr_s[1]), .data_out_debug(dout_s[1]),
    .tx_data(tx_data_s[1]), .tx_valid(tx_valid_s[1]), .tx_ready(tx_ready_s[1]),
    .busy(busy_s[1]), .done(done_s[1]));

  // Register file models: data follows the address after 1 and 3 clocks.
  always @(posedge clk) begin
    ap0    <= addr_s[0];
    ap1[0] <= addr_s[1];
    ap1[1] <= ap1[0];
    ap1[2] <= ap1[1];
  end
  always_comb begin
    dout_s[0] = mem[0][ap0];
    dout_s[1] = mem[1][ap1[2]];
  end

  always @(posedge clk) begin
    #1;
    for (int u = 0; u < 2; u++) tx_ready_s[u] = ($urandom_range(99) < rdy_pct[u]);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: byte capture, done pulse count, stall stability.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        prev_stall[u] = 1'b0;
      end else begin
        if (prev_stall[u] && tx_valid_s[u])
          chk($sformatf("stall_hold%0d", u), tx_data_s[u], stall_byte[u]);
        if (tx_valid_s[u] && tx_ready_s[u]) got_q[u].push_back(tx_data_s[u]);
        if (done_s[u]) done_cnt[u]++;
        prev_stall[u] = tx_valid_s[u] && !tx_ready_s[u];
        stall_byte[u] = tx_data_s[u];
      end
    end
  end

  always @(negedge clk)
    if (mut_en && addr_s[0] == 5'd5 && tx_valid_s[0]) mem[0][5] = 32'hFFFF_FFFF;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_spec_mem();
    for (int r = 0; r < NREG; r++) mem[0][r] = '0;
    mem[0][2] = 32'h7FFF_EFFC;
  endtask

  function automatic void build_frame(input int u);
    logic [7:0] cs = '0;
    logic [7:0] b;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int r = 0; r < NREG; r++)
      for (int k = 3; k >= 0; k--) begin
        b = 8'(mem[u][r] >> (8 * k));
        exp_q.push_back(b);
        cs ^= b;
      end
    exp_q.push_back(cs);
  endfunction

  task automatic wait_bytes(input int u, input int n);
    bit ok = 1'b0;
    for (int c = 0; c < 4000 && !ok; c++) begin
      step();
      ok = (got_q[u].size() >= n);
    end
    chk($sformatf("reach_byte_%0d", n), 32'(ok), 1);
  endtask

  task automatic quiet(input int u, input int n, input string label);
    int v = 0;
    for (int c = 0; c < n; c++) begin
      step();
      if (tx_valid_s[u] || busy_s[u]) v++;
    end
    chk({label, "_idle"}, v, 0);
  endtask

  task automatic finish_frame(input int u, input string label, input bit mid_start);
    bit fin = 1'b0;
    bit busy_ok = 1'b1;
    for (int c = 0; c < 6000 && !fin; c++) begin
      start_s[u] = mid_start && (c == 100);
      step();
      if (done_s[u]) fin = 1'b1;
      else if (!busy_s[u]) busy_ok = 1'b0;
    end
    start_s[u] = 1'b0;
    chk({label, "_done_seen"}, 32'(fin), 1);
    chk({label, "_busy_held"}, 32'(busy_ok), 1);
    step();
    chk({label, "_busy_clear"}, 32'(busy_s[u]), 0);
    repeat (4) step();
    chk({label, "_done_count"}, done_cnt[u], 1);
    chk({label, "_len"}, got_q[u].size(), frame_len(NREG, 32));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q[u].size()) chk($sformatf("%s_byte%0d", label, i), got_q[u][i], exp_q[i]);
  endtask

  task automatic run_frame(input int u, input string label, input bit mid_start);
    build_frame(u);
    got_q[u].delete();
    done_cnt[u] = 0;
    start_s[u] = 1'b1;
    step();
    start_s[u] = 1'b0;
    finish_frame(u, label, mid_start);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] db;
    tbl[0]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 5'd0};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0};
    tbl[4]  = '{1'b0, 1'b1, 8'h00, 1'b1, 5'd0};
    tbl[5]  = '{1'b0, 1'b1, 8'h00, 1'b1, 5'd0};
    tbl[6]  = '{1'b0, 1'b1, 8'h00, 1'b1, 5'd0};
    tbl[7]  = '{1'b0, 1'b1, 8'h00, 1'b1, 5'd0};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd1};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd1};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd1};
    tbl[11] = '{1'b0, 1'b1, 8'h00, 1'b1, 5'd1};

    rst = 1'b1;
    mut_en = 1'b0;
    for (int u = 0; u < 2; u++) begin
      start_s[u] = 1'b0;
      abort_s[u] = 1'b0;
      done_cnt[u] = 0;
    end
    set_spec_mem();
    for (int r = 0; r < NREG; r++) mem[1][r] = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_addr", addr_s[0], 0);
    chk("rst_data", tx_data_s[0], 0);
    chk("rst_valid", 32'(tx_valid_s[0]), 0);
    chk("rst_busy", 32'(busy_s[0]), 0);
    chk("rst_done", 32'(done_s[0]), 0);
    rst = 1'b0;
    step();
    chk("idle_valid", 32'(tx_valid_s[0]), 0);

    // 1: cycle table for the opening of a frame, then the whole frame.
    build_frame(0);
    got_q[0].delete();
    done_cnt[0] = 0;
    for (int i = 0; i < 12; i++) begin
      start_s[0] = tbl[i].start;
      step();
      chk($sformatf("tbl%0d_valid", i), 32'(tx_valid_s[0]), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) chk($sformatf("tbl%0d_data", i), tx_data_s[0], tbl[i].exp_data);
      chk($sformatf("tbl%0d_busy", i), 32'(busy_s[0]), 32'(tbl[i].exp_busy));
      chk($sformatf("tbl%0d_addr", i), addr_s[0], tbl[i].exp_addr);
      chk($sformatf("tbl%0d_done", i), 32'(done_s[0]), 0);
    end
    start_s[0] = 1'b0;
    finish_frame(0, "t1", 1'b0);
    if (got_q[0].size() >= 130) begin
      chk("t1_reg2_b0", got_q[0][9], 8'h7F);
      chk("t1_reg2_b3", got_q[0][12], 8'hFC);
      chk("t1_csum", got_q[0][129], 8'h93);
    end

    // 2: stalls on the transmitter, register changed while it is being sent.
    rdy_pct[0] = 30;
    mut_en = 1'b1;
    run_frame(0, "t2", 1'b0);
    mut_en = 1'b0;
    set_spec_mem();

    // Random register contents.
    for (int r = 0; r < NREG; r++) mem[0][r] = $urandom;
    rdy_pct[0] = 60;
    run_frame(0, "rnd", 1'b0);
    set_spec_mem();

    // 3: read latency 3.
    for (int r = 0; r < NREG - 1; r++) mem[1][r] = $urandom;
    mem[1][31] = 32'hDEAD_BEEF;
    rdy_pct[1] = 70;
    run_frame(1, "t3", 1'b0);
    db = 32'hDEAD_BEEF;
    if (got_q[1].size() >= 129)
      for (int k = 0; k < 4; k++) chk($sformatf("t3_last%0d", k), got_q[1][125 + k], db[31 - 8 * k -: 8]);

    // 4: abort during register 10 byte 2, then a clean frame.
    rdy_pct[0] = 100;
    build_frame(0);
    got_q[0].delete();
    done_cnt[0] = 0;
    start_s[0] = 1'b1;
    step();
    start_s[0] = 1'b0;
    wait_bytes(0, 43);
    step();
    chk("t4_addr", addr_s[0], 10);
    chk("t4_byte", tx_data_s[0], exp_q[43]);
    abort_s[0] = 1'b1;
    step();
    abort_s[0] = 1'b0;
    chk("t4_valid", 32'(tx_valid_s[0]), 0);
    chk("t4_busy", 32'(busy_s[0]), 0);
    quiet(0, 30, "t4");
    chk("t4_no_done", done_cnt[0], 0);
    run_frame(0, "t4r", 1'b0);

    // 5: start while busy; abort with start mid-frame; abort with start idle.
    run_frame(0, "t5", 1'b1);
    quiet(0, 30, "t5_after");
    got_q[0].delete();
    done_cnt[0] = 0;
    start_s[0] = 1'b1;
    step();
    start_s[0] = 1'b0;
    wait_bytes(0, 20);
    abort_s[0] = 1'b1;
    start_s[0] = 1'b1;
    step();
    abort_s[0] = 1'b0;
    start_s[0] = 1'b0;
    chk("t5b_valid", 32'(tx_valid_s[0]), 0);
    chk("t5b_busy", 32'(busy_s[0]), 0);
    quiet(0, 30, "t5b");
    chk("t5b_no_done", done_cnt[0], 0);
    abort_s[0] = 1'b1;
    start_s[0] = 1'b1;
    step();
    abort_s[0] = 1'b0;
    start_s[0] = 1'b0;
    quiet(0, 10, "t5c");

    // 6: asynchronous reset mid-SEND, then a full frame.
    got_q[0].delete();
    start_s[0] = 1'b1;
    step();
    start_s[0] = 1'b0;
    wait_bytes(0, 60);
    chk("t6_sending", 32'(tx_valid_s[0]), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_valid", 32'(tx_valid_s[0]), 0);
    chk("t6_data", tx_data_s[0], 0);
    chk("t6_busy", 32'(busy_s[0]), 0);
    chk("t6_addr", addr_s[0], 0);
    chk("t6_done", 32'(done_s[0]), 0);
    #13;
    rst = 1'b0;
    step();
    run_frame(0, "t6r", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
